// File: rtl/yuv_fb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : yuv_fb_pkg                                                 |
// | Description : Shared types and constants for the YUV frame-buffer        |
// |               pixel fetch sequencer: FSM state encoding, memory buffer   |
// |               select codes and default frame geometry.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package yuv_fb_pkg;

   // Default frame geometry and memory word width
   localparam int DEF_WIDTH  = 320;
   localparam int DEF_HEIGHT = 240;
   localparam int DEF_MEM_W  = 256;

   // Memory buffer select encodings driven on mem_sel
   localparam logic [1:0] SEL_Y  = 2'd0;
   localparam logic [1:0] SEL_U0 = 2'd1;
   localparam logic [1:0] SEL_U1 = 2'd2;
   localparam logic [1:0] SEL_V  = 2'd3;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_FETCH_Y = 3'd2,
      ST_FETCH_U = 3'd3,
      ST_FETCH_V = 3'd4,
      ST_EMIT    = 3'd5
   } state_e;

endpackage : yuv_fb_pkg
`default_nettype wire

// File: rtl/yuv_pixel_fetch_ctrl_plane_word_cache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : plane_word_cache                                           |
// | Description : One-word tag cache for a single YUV plane. Holds the last  |
// |               fetched memory word with its tag and extracts the byte at  |
// |               a bit offset, either from the cached word or directly from |
// |               the word being filled in the current cycle.                |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports                                                                    |
// |   clk, rst_n   clock, asynchronous active-low reset                      |
// |   inval_i      clear the valid flag                                      |
// |   tag_i        lookup tag (compared against stored tag)                  |
// |   pos_i        bit offset of the addressed byte                          |
// |   fill_i       store fill_data_i and tag_i, set valid                    |
// |   fill_data_i  memory word being returned                                |
// |   hit_o        valid and tag match                                       |
// |   byte_o       addressed byte (from fill data when filling)              |
// +--------------------------------------------------------------------------+
module plane_word_cache #(
   parameter int MEM_W = 256,
   parameter int TAG_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inval_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic [7:0]       pos_i,
   input  logic             fill_i,
   input  logic [MEM_W-1:0] fill_data_i,
   output logic             hit_o,
   output logic [7:0]       byte_o
);

   logic             valid_q;
   logic [TAG_W-1:0] tag_q;
   logic [MEM_W-1:0] word_q;
   logic [MEM_W-1:0] src_word;
   logic [MEM_W-1:0] shifted;

   assign hit_o = valid_q && (tag_q == tag_i);

   // On a fill the byte comes straight from the returning word so the
   // component is captured in the same cycle as mem_rvalid.
   assign src_word = fill_i ? fill_data_i : word_q;
   assign shifted  = src_word >> pos_i;
   assign byte_o   = shifted[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         word_q  <= '0;
      end else if (inval_i) begin
         valid_q <= 1'b0;
      end else if (fill_i) begin
         valid_q <= 1'b1;
         tag_q   <= tag_i;
         word_q  <= fill_data_i;
      end
   end

endmodule : plane_word_cache
`default_nettype wire

// File: rtl/yuv_pixel_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : yuv_pixel_fetch_ctrl                                       |
// | Description : Raster-scan sequencer for the YUV frame buffer. Walks      |
// |               row/col over one frame, latches the external XY2ADDRESS    |
// |               converter outputs, fetches the Y, U and V words (skipping  |
// |               reads that hit the per-plane word cache), extracts the     |
// |               addressed bytes and hands one pixel per handshake to the   |
// |               consumer.                                                  |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports                                                                    |
// |   clk, rst_n                clock, asynchronous active-low reset         |
// |   start                     begin a frame at (0,0) when idle             |
// |   busy, frame_done          frame in progress / end-of-frame pulse       |
// |   row, col                  coordinates to the converter                 |
// |   u_fb, y/u/v_addr, *_pos   converter outputs                            |
// |   mem_req/addr/sel          single-word read request                     |
// |   mem_rvalid, mem_rdata     read response                                |
// |   pix_valid/ready, pix_*    pixel stream to the consumer                 |
// +--------------------------------------------------------------------------+
module yuv_pixel_fetch_ctrl
   import yuv_fb_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int MEM_W  = DEF_MEM_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             frame_done,
   output logic [9:0]       row,
   output logic [9:0]       col,
   input  logic             u_fb,
   input  logic [15:0]      y_addr,
   input  logic [15:0]      u_addr,
   input  logic [12:0]      v_addr,
   input  logic [5:0]       y_pos,
   input  logic [7:0]       u_pos,
   input  logic [7:0]       v_pos,
   output logic             mem_req,
   output logic [15:0]      mem_addr,
   output logic [1:0]       mem_sel,
   input  logic             mem_rvalid,
   input  logic [MEM_W-1:0] mem_rdata,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [7:0]       pix_y,
   output logic [7:0]       pix_u,
   output logic [7:0]       pix_v
);

   localparam logic [9:0] LAST_COL = 10'(WIDTH - 1);
   localparam logic [9:0] LAST_ROW = 10'(HEIGHT - 1);

   state_e      state_q, state_d;

   logic [9:0]  row_q, col_q;
   logic        frame_done_q;
   logic [7:0]  pix_y_q, pix_u_q, pix_v_q;

   // Converter outputs captured in SETTLE
   logic [15:0] y_addr_q, u_addr_q, v_addr_q;
   logic [7:0]  y_pos_q, u_pos_q, v_pos_q;
   logic        u_fb_q;

   logic        cache_inval;
   logic        y_hit, u_hit, v_hit;
   logic        y_fill, u_fill, v_fill;
   logic        y_take, u_take, v_take;
   logic [7:0]  y_byte, u_byte, v_byte;
   logic        hs_ok;
   logic        last_pix;

   assign hs_ok       = (state_q == ST_EMIT) && pix_ready;
   assign last_pix    = (row_q == LAST_ROW) && (col_q == LAST_COL);
   assign cache_inval = (state_q == ST_IDLE) && start;

   // ------------------------------------------------------------------
   // Plane caches; the U tag carries the buffer select so the same word
   // address in the other U buffer is a miss.
   // ------------------------------------------------------------------
   plane_word_cache #(.MEM_W(MEM_W), .TAG_W(16)) u_cache_y (
      .clk         (clk),
      .rst_n       (rst_n),
      .inval_i     (cache_inval),
      .tag_i       (y_addr_q),
      .pos_i       (y_pos_q),
      .fill_i      (y_fill),
      .fill_data_i (mem_rdata),
      .hit_o       (y_hit),
      .byte_o      (y_byte)
   );

   plane_word_cache #(.MEM_W(MEM_W), .TAG_W(17)) u_cache_u (
      .clk         (clk),
      .rst_n       (rst_n),
      .inval_i     (cache_inval),
      .tag_i       ({u_fb_q, u_addr_q}),
      .pos_i       (u_pos_q),
      .fill_i      (u_fill),
      .fill_data_i (mem_rdata),
      .hit_o       (u_hit),
      .byte_o      (u_byte)
   );

   plane_word_cache #(.MEM_W(MEM_W), .TAG_W(16)) u_cache_v (
      .clk         (clk),
      .rst_n       (rst_n),
      .inval_i     (cache_inval),
      .tag_i       (v_addr_q),
      .pos_i       (v_pos_q),
      .fill_i      (v_fill),
      .fill_data_i (mem_rdata),
      .hit_o       (v_hit),
      .byte_o      (v_byte)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start)     state_d = ST_SETTLE;
         ST_SETTLE:                 state_d = ST_FETCH_Y;
         ST_FETCH_Y: if (y_take)    state_d = ST_FETCH_U;
         ST_FETCH_U: if (u_take)    state_d = ST_FETCH_V;
         ST_FETCH_V: if (v_take)    state_d = ST_EMIT;
         ST_EMIT:    if (pix_ready) state_d = last_pix ? ST_IDLE : ST_SETTLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs. A request is raised only on a miss; mem_rvalid is
   // honoured only while that request is up, so stray or late responses
   // cannot fill a cache.
   // ------------------------------------------------------------------
   always_comb begin
      mem_req  = 1'b0;
      mem_addr = 16'd0;
      mem_sel  = SEL_Y;
      y_fill   = 1'b0;
      u_fill   = 1'b0;
      v_fill   = 1'b0;
      y_take   = 1'b0;
      u_take   = 1'b0;
      v_take   = 1'b0;
      case (state_q)
         ST_FETCH_Y: begin
            if (y_hit) begin
               y_take = 1'b1;
            end else begin
               mem_req  = 1'b1;
               mem_addr = y_addr_q;
               mem_sel  = SEL_Y;
               y_fill   = mem_rvalid;
               y_take   = mem_rvalid;
            end
         end
         ST_FETCH_U: begin
            if (u_hit) begin
               u_take = 1'b1;
            end else begin
               mem_req  = 1'b1;
               mem_addr = u_addr_q;
               mem_sel  = u_fb_q ? SEL_U1 : SEL_U0;
               u_fill   = mem_rvalid;
               u_take   = mem_rvalid;
            end
         end
         ST_FETCH_V: begin
            if (v_hit) begin
               v_take = 1'b1;
            end else begin
               mem_req  = 1'b1;
               mem_addr = v_addr_q;
               mem_sel  = SEL_V;
               v_fill   = mem_rvalid;
               v_take   = mem_rvalid;
            end
         end
         default: begin
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign pix_valid = (state_q == ST_EMIT);

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q        <= 10'd0;
         col_q        <= 10'd0;
         frame_done_q <= 1'b0;
         pix_y_q      <= 8'd0;
         pix_u_q      <= 8'd0;
         pix_v_q      <= 8'd0;
         y_addr_q     <= 16'd0;
         u_addr_q     <= 16'd0;
         v_addr_q     <= 16'd0;
         y_pos_q      <= 8'd0;
         u_pos_q      <= 8'd0;
         v_pos_q      <= 8'd0;
         u_fb_q       <= 1'b0;
      end else begin
         frame_done_q <= hs_ok && last_pix;

         if (cache_inval) begin
            row_q <= 10'd0;
            col_q <= 10'd0;
         end else if (hs_ok && !last_pix) begin
            if (col_q == LAST_COL) begin
               col_q <= 10'd0;
               row_q <= row_q + 10'd1;
            end else begin
               col_q <= col_q + 10'd1;
            end
         end

         if (state_q == ST_SETTLE) begin
            y_addr_q <= y_addr;
            u_addr_q <= u_addr;
            v_addr_q <= {3'b000, v_addr};
            y_pos_q  <= {2'b00, y_pos};
            u_pos_q  <= u_pos;
            v_pos_q  <= v_pos;
            u_fb_q   <= u_fb;
         end

         if (y_take) pix_y_q <= y_byte;
         if (u_take) pix_u_q <= u_byte;
         if (v_take) pix_v_q <= v_byte;
      end
   end

   assign frame_done = frame_done_q;
   assign row        = row_q;
   assign col        = col_q;
   assign pix_y      = pix_y_q;
   assign pix_u      = pix_u_q;
   assign pix_v      = pix_v_q;

endmodule : yuv_pixel_fetch_ctrl
`default_nettype wire

// File: doc/yuv_pixel_fetch_ctrl.md
# yuv_pixel_fetch_ctrl

Raster-scan sequencer for the YUV frame buffer. It walks row/col across one frame and drives the existing combinational XY2ADDRESS converter. For each pixel it issues up to three single-word memory reads (Y, U, V) and extracts the addressed bytes, then presents one YUV pixel per handshake to the downstream pixel consumer. A one-word tag cache per plane suppresses repeat reads of the same word.

## Interface
- WIDTH, 320: pixels per row
- HEIGHT, 240: rows per frame
- MEM_W, 256: memory read word width in bits
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  pulse; begin a frame at (0,0); ignored unless idle
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel handshake
- row, col  out  10 each  current pixel coordinates to the converter
- u_fb  in  1  converter U frame-buffer select
- y_addr, u_addr  in  16 each  converter word addresses
- v_addr  in  13  converter word address; zero-extended to 16
- y_pos  in  6  bit offset of the Y byte in the word; zero-extended
- u_pos, v_pos  in  8 each  bit offsets of the U and V bytes
- mem_req  out  1  read request
- mem_addr  out  16  read address
- mem_sel  out  2  buffer select: 0 = Y, 1 = U buffer 0, 2 = U buffer 1, 3 = V
- mem_rvalid  in  1  read data valid
- mem_rdata  in  MEM_W  read data
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_y, pix_u, pix_v  out  8 each  pixel components

## Operation
- States: IDLE, SETTLE, FETCH_Y, FETCH_U, FETCH_V, EMIT.
- IDLE, start=1: row=col=0, invalidate all three caches, busy=1, go to SETTLE.
- SETTLE: one cycle for converter outputs to settle. Latch all addresses, positions and u_fb into internal registers. Go to FETCH_Y.
- FETCH_x, cache hit (valid and tag equal to the latched address, with u_fb included in the U tag):
  - extract the byte and advance next cycle
  - no mem_req
- FETCH_x, miss:
  - hold mem_req=1 with mem_addr/mem_sel stable until the cycle mem_rvalid=1
  - in that cycle store mem_rdata and tag in the cache, set valid, and extract the byte
  - deassert mem_req the following cycle
- Byte extraction: component = word[pos +: 8]. Positions above MEM_W-8 are illegal and produce undefined data; this is not checked.
- mem_rvalid while mem_req=0 is ignored.
- EMIT: pix_valid=1, components stable until pix_ready=1. On handshake:
  - col increments
  - at col=WIDTH-1: col=0 and row increments, go to SETTLE
  - at the last pixel (HEIGHT-1, WIDTH-1): pulse frame_done, busy=0, go to IDLE; row/col hold their final values
- start while busy: ignored.
- rst_n low at any time: immediately IDLE; caches invalid; any in-flight memory read is abandoned; a late mem_rvalid after reset is ignored.

## Timing
- Reset values: busy, frame_done, mem_req, pix_valid = 0; row, col, mem_addr, mem_sel, pix_y/u/v = 0.
- mem_rvalid is legal at the earliest one cycle after mem_req rises.
- Pixel latency from entering SETTLE to pix_valid:
  - all-hit: 4 cycles (SETTLE plus three FETCH cycles)
  - all-miss, minimum memory latency: 7 cycles
- Pixel throughput with pix_ready held high: one pixel per (latency + 1) cycles.
- frame_done is asserted in the cycle after the final EMIT handshake; busy falls in that same cycle.

## Structure
- Shared package yuv_fb_pkg holds:
  - the state enum
  - the mem_sel encodings (SEL_Y, SEL_U0, SEL_U1, SEL_V)
  - the default WIDTH/HEIGHT/MEM_W constants
- Natural sub-module: plane_word_cache (tag, valid, word, byte extract), instantiated three times.
- The XY2ADDRESS converter is instantiated outside this block so the bench can drive converter outputs directly.

## Test plan
- Reset mid-fetch: assert rst_n=0 while mem_req=1 -> all outputs 0, state IDLE. Then start with a miss -> a fresh request is issued, proving the cache was invalidated.
- First pixel, all miss: start, converter gives y_addr=0, u_addr=61440, u_fb=0, v_addr=3128, all pos=0. Memory returns words with byte0=0x11/0x22/0x33 after 1 cycle -> requests in order sel 0/addr 0, sel 1/addr 61440, sel 3/addr 3128. Then pix=(0x11,0x22,0x33) valid 7 cycles after SETTLE.
- Cache hit: next pixel with same addresses, y_pos=8 -> no mem_req; pix_y = bits [15:8] of the cached Y word; latency 4.
- U buffer switch: same u_addr with u_fb=1 -> miss, mem_sel=2.
- Backpressure: hold pix_ready=0 for 5 cycles -> pix_valid and data stable, col unchanged. Handshake then advances col by 1.
- Frame wrap: WIDTH=4, HEIGHT=2 with always-ready memory and consumer -> 8 handshakes, row/col sequence is raster order, one frame_done pulse, busy=0. A start issued during the frame is ignored.
